// File: rtl/dma16_pkg.sv
// Shared constants and types for the 16-bank source/sink DMA pair.
// The write-side DMA imports the same package so bank geometry stays in one place.
package dma16_pkg;
    localparam int NUM_BANKS  = 16;
    localparam int BANK_DEPTH = 940;
    localparam int ADDR_W     = 10;
    localparam int SEL_W      = 4;
    localparam int DATA_W     = 8;
    localparam int ENTRY_W    = DATA_W + 1 + SEL_W;

    localparam logic [ADDR_W-1:0] LAST_ADDR = 10'd939;

    typedef enum logic {
        IDLE,
        READ
    } dma16_state_t;

    // One buffered stream beat: the byte plus the tags that travel with it.
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              last;
        logic [SEL_W-1:0]  bank;
    } dma16_entry_t;
endpackage

// File: rtl/sink_dma_skid_fifo.sv
// Two-entry FIFO between the 1-cycle-latency RAM read and the output stream.
// The caller never pushes into a full FIFO and never pops an empty one.
module sink_dma_skid_fifo
    import dma16_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic         i_pop,
    input  dma16_entry_t i_wdata,
    output dma16_entry_t o_rdata,
    output logic [1:0]   o_count
);
    dma16_entry_t r_mem [2];
    logic         r_wr_ptr;
    logic         r_rd_ptr;
    logic [1:0]   r_count;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_entry
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_mem[gi] <= '0;
                end else if (i_push && (r_wr_ptr == 1'(gi))) begin
                    r_mem[gi] <= i_wdata;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (i_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + 2'(i_push) - 2'(i_pop);
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_count = r_count;
endmodule

// File: rtl/sink_dma_16.sv
// Read-side DMA: drains filled RAM banks in write order onto a valid/ready byte
// stream, tagging each byte with its bank and marking the last byte of a bank.
module sink_dma_16
    import dma16_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              bank_filled,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_address,
    output logic [SEL_W-1:0]  rd_select,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic [SEL_W-1:0]  out_bank,
    output logic [4:0]        banks_pending,
    output logic              overflow
);
    dma16_state_t      r_state;
    dma16_state_t      w_state_next;
    logic [4:0]        r_pending;
    logic [4:0]        w_pending_next;
    logic              r_overflow;
    logic              w_overflow_set;
    logic [ADDR_W-1:0] r_addr;
    logic [SEL_W-1:0]  r_sel;
    logic              r_inflight;
    logic              r_tag_last;
    logic [SEL_W-1:0]  r_tag_bank;

    logic              w_issue;
    logic              w_issue_last;
    logic              w_pop;
    logic [1:0]        w_fifo_count;
    dma16_entry_t      w_fifo_rdata;
    dma16_entry_t      w_fifo_wdata;

    always_comb begin
        w_pop          = (w_fifo_count != 2'd0) && out_ready;
        w_issue        = 1'b0;
        w_overflow_set = 1'b0;
        w_pending_next = r_pending;
        w_state_next   = r_state;

        // Count the in-flight read as already buffered so the FIFO can never overfill.
        if (r_state == READ) begin
            w_issue = ({1'b0, w_fifo_count} + {2'b00, r_inflight}) < (3'd2 + {2'b00, w_pop});
        end
        w_issue_last = w_issue && (r_addr == LAST_ADDR);

        case ({bank_filled, w_issue_last})
            2'b10: begin
                if (r_pending == 5'd16) begin
                    w_overflow_set = 1'b1;
                end else begin
                    w_pending_next = r_pending + 5'd1;
                end
            end
            2'b01:   w_pending_next = r_pending - 5'd1;
            default: w_pending_next = r_pending;
        endcase

        // Decide on the updated count so the first read issues the cycle after the fill pulse.
        case (r_state)
            IDLE: begin
                if (w_pending_next != 5'd0) begin
                    w_state_next = READ;
                end
            end
            READ: begin
                if (w_issue_last && (w_pending_next == 5'd0)) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_pending  <= 5'd0;
            r_overflow <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_pending <= w_pending_next;
            if (w_overflow_set) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr     <= '0;
            r_sel      <= '0;
            r_inflight <= 1'b0;
            r_tag_last <= 1'b0;
            r_tag_bank <= '0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_tag_last <= w_issue_last;
                r_tag_bank <= r_sel;
                if (w_issue_last) begin
                    r_addr <= '0;
                    r_sel  <= r_sel + SEL_W'(1);
                end else begin
                    r_addr <= r_addr + ADDR_W'(1);
                end
            end
        end
    end

    assign w_fifo_wdata.data = rd_data;
    assign w_fifo_wdata.last = r_tag_last;
    assign w_fifo_wdata.bank = r_tag_bank;

    sink_dma_skid_fifo u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_inflight),
        .i_pop   (w_pop),
        .i_wdata (w_fifo_wdata),
        .o_rdata (w_fifo_rdata),
        .o_count (w_fifo_count)
    );

    assign rd_en         = w_issue;
    assign rd_address    = r_addr;
    assign rd_select     = r_sel;
    assign out_valid     = (w_fifo_count != 2'd0);
    assign out_data      = w_fifo_rdata.data;
    assign out_last      = w_fifo_rdata.last;
    assign out_bank      = w_fifo_rdata.bank;
    assign banks_pending = r_pending;
    assign overflow      = r_overflow;
endmodule
